axi_stream_insert_arbiter: RTL

- Shares one `axi_stream_header_insert` datapath between `NUM_SRC` requesters.
- Each requester presents a header (insert channel) and a payload stream.
- The arbiter grants one requester at a time, round-robin, and muxes its header and then its payload into the insert block.
- It holds the grant until the insert block's output packet completes, so headers and payloads of different sources never interleave.

---
 rtl/axi_stream_insert_arbiter_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/axi_stream_insert_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/axi_stream_insert_arbiter_pkg.sv
// Shared types and widths for the header-insert arbiter.
package axi_insert_arb_pkg;

  // Arbiter FSM: wait for request, pass header, pass payload, wait for packet end.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HDR   = 2'd1,
    DATA  = 2'd2,
    DRAIN = 2'd3
  } arb_state_e;

  localparam int PKT_CNT_WD = 16;  // completed-packet counter width
  localparam int WD_CNT_WD  = 16;  // DRAIN watchdog counter width

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request searching from ptr+1
// upward, wrapping modulo NUM_SRC.
module rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int SRC_WD  = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_WD-1:0]  ptr,
  output logic [SRC_WD-1:0]  gnt_idx,
  output logic               gnt_any
);

  logic [SRC_WD-1:0] w_cand;

  // Walk candidates farthest-first so the nearest requester after ptr wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it holding a value (no latch).
    gnt_idx = '0;
    gnt_any = 1'b0;
    w_cand  = '0;
    for (int i = NUM_SRC; i >= 1; i--) begin
      w_cand = SRC_WD'((int'(ptr) + i) % NUM_SRC);
      if (req[w_cand]) begin
        gnt_idx = w_cand;
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_stream_insert_arbiter.sv
// Round-robin arbiter sharing one header-insert datapath between NUM_SRC
// requesters. The grant is held from header handshake until the insert block
// reports packet completion, so sources never interleave.
module axi_stream_insert_arbiter
  import axi_insert_arb_pkg::*;
#(
  parameter int DATA_WD       = 32,
  parameter int DATA_BYTE_WD  = DATA_WD / 8,
  parameter int BYTE_CNT_WD   = $clog2(DATA_BYTE_WD),
  parameter int NUM_SRC       = 4,
  parameter int SRC_WD        = $clog2(NUM_SRC),
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_SRC-1:0]                   s_valid_insert,
  input  logic [NUM_SRC*DATA_WD-1:0]           s_data_insert,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0]      s_keep_insert,
  input  logic [NUM_SRC*(BYTE_CNT_WD+1)-1:0]   s_byte_insert_cnt,
  output logic [NUM_SRC-1:0]                   s_ready_insert,
  input  logic [NUM_SRC-1:0]                   s_valid_in,
  input  logic [NUM_SRC-1:0]                   s_last_in,
  input  logic [NUM_SRC*DATA_WD-1:0]           s_data_in,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0]      s_keep_in,
  output logic [NUM_SRC-1:0]                   s_ready_in,
  output logic                                 m_valid_insert,
  output logic [DATA_WD-1:0]                   m_data_insert,
  output logic [DATA_BYTE_WD-1:0]              m_keep_insert,
  output logic [BYTE_CNT_WD:0]                 m_byte_insert_cnt,
  input  logic                                 m_ready_insert,
  output logic                                 m_valid_in,
  output logic [DATA_WD-1:0]                   m_data_in,
  output logic [DATA_BYTE_WD-1:0]              m_keep_in,
  output logic                                 m_last_in,
  input  logic                                 m_ready_in,
  input  logic                                 pkt_done,
  output logic [SRC_WD-1:0]                    grant_id,
  output logic                                 busy,
  output logic [PKT_CNT_WD-1:0]                pkt_cnt,
  output logic                                 err_timeout
);

  arb_state_e              r_state;
  logic [SRC_WD-1:0]       r_grant;
  logic [SRC_WD-1:0]       r_rr_ptr;
  logic                    r_done_seen;
  logic [PKT_CNT_WD-1:0]   r_pkt_cnt;
  logic [WD_CNT_WD-1:0]    r_wd_cnt;
  logic                    r_err_timeout;

  logic [SRC_WD-1:0]       w_gnt_idx;
  logic                    w_gnt_any;
  logic                    w_hdr_hs;
  logic                    w_last_hs;
  logic                    w_wd_expire;

  // Per-source views of the packed input buses, indexed by grant.
  logic [DATA_WD-1:0]      w_hdr_data [NUM_SRC];
  logic [DATA_BYTE_WD-1:0] w_hdr_keep [NUM_SRC];
  logic [BYTE_CNT_WD:0]    w_hdr_cnt  [NUM_SRC];
  logic [DATA_WD-1:0]      w_pay_data [NUM_SRC];
  logic [DATA_BYTE_WD-1:0] w_pay_keep [NUM_SRC];

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
    assign w_hdr_data[g] = s_data_insert[g*DATA_WD +: DATA_WD];
    assign w_hdr_keep[g] = s_keep_insert[g*DATA_BYTE_WD +: DATA_BYTE_WD];
    assign w_hdr_cnt[g]  = s_byte_insert_cnt[g*(BYTE_CNT_WD+1) +: (BYTE_CNT_WD+1)];
    assign w_pay_data[g] = s_data_in[g*DATA_WD +: DATA_WD];
    assign w_pay_keep[g] = s_keep_in[g*DATA_BYTE_WD +: DATA_BYTE_WD];
  end

  rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .SRC_WD  (SRC_WD)
  ) u_rr_arbiter (
    .req     (s_valid_insert),
    .ptr     (r_rr_ptr),
    .gnt_idx (w_gnt_idx),
    .gnt_any (w_gnt_any)
  );

  assign w_hdr_hs    = m_valid_insert & m_ready_insert;
  assign w_last_hs   = m_valid_in & m_ready_in & m_last_in;
  assign w_wd_expire = (r_wd_cnt == WD_CNT_WD'(DRAIN_TIMEOUT - 1));

  // Route the granted source to the insert block; everything else is held at 0.
  always_comb begin
    m_valid_insert    = 1'b0;
    m_data_insert     = '0;
    m_keep_insert     = '0;
    m_byte_insert_cnt = '0;
    m_valid_in        = 1'b0;
    m_data_in         = '0;
    m_keep_in         = '0;
    m_last_in         = 1'b0;
    s_ready_insert    = '0;
    s_ready_in        = '0;
    case (r_state)
      HDR: begin
        m_valid_insert          = s_valid_insert[r_grant];
        m_data_insert           = w_hdr_data[r_grant];
        m_keep_insert           = w_hdr_keep[r_grant];
        m_byte_insert_cnt       = w_hdr_cnt[r_grant];
        s_ready_insert[r_grant] = m_ready_insert;
      end
      DATA: begin
        m_valid_in          = s_valid_in[r_grant];
        m_data_in           = w_pay_data[r_grant];
        m_keep_in           = w_pay_keep[r_grant];
        m_last_in           = s_last_in[r_grant];
        s_ready_in[r_grant] = m_ready_in;
      end
      default: ;
    endcase
  end

  // Arbitration FSM with packet counter, DRAIN watchdog and done tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_rr_ptr      <= SRC_WD'(NUM_SRC - 1);
      r_done_seen   <= 1'b0;
      r_pkt_cnt     <= '0;
      r_wd_cnt      <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      // NOTE: state updates use <= so every register samples pre-edge values, regardless of statement order.
      r_err_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt_any) begin
            r_grant <= w_gnt_idx;
            r_state <= HDR;
          end
        end
        HDR: begin
          if (w_hdr_hs) r_state <= DATA;
        end
        DATA: begin
          if (w_last_hs) begin
            if (r_done_seen | pkt_done) begin
              r_state     <= IDLE;
              r_rr_ptr    <= r_grant;
              r_pkt_cnt   <= r_pkt_cnt + 1'b1;
              r_done_seen <= 1'b0;
            end else begin
              r_state <= DRAIN;
            end
          end else if (pkt_done) begin
            // Insert block may flag its last beat before our last payload handshake.
            r_done_seen <= 1'b1;
          end
        end
        DRAIN: begin
          if (pkt_done) begin
            r_state   <= IDLE;
            r_rr_ptr  <= r_grant;
            r_pkt_cnt <= r_pkt_cnt + 1'b1;
            r_wd_cnt  <= '0;
          end else if (w_wd_expire) begin
            r_state       <= IDLE;
            r_rr_ptr      <= r_grant;
            r_err_timeout <= 1'b1;
            r_wd_cnt      <= '0;
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant_id    = r_grant;
  assign busy        = (r_state != IDLE);
  assign pkt_cnt     = r_pkt_cnt;
  assign err_timeout = r_err_timeout;

endmodule
